// File: rtl/usb_pkg.sv
// Shared types for the USB bulk-endpoint control units (RX, TX and protocol
// sequencer).
//   rx_pkt_t     : packet types decoded by the RX control unit
//   tx_pkt_t     : packet types the TX control unit can send
//   ctrl_state_t : protocol sequencer states
package usb_pkg;

    localparam int unsigned RESP_TIMEOUT_DEF = 144;

    typedef enum logic [2:0] {
        RX_NONE = 3'd0,
        RX_OUT  = 3'd1,
        RX_IN   = 3'd2,
        RX_DATA = 3'd3,
        RX_ACK  = 3'd4,
        RX_NAK  = 3'd5
    } rx_pkt_t;

    typedef enum logic [1:0] {
        TX_NONE = 2'd0,
        TX_DATA = 2'd1,
        TX_ACK  = 2'd2,
        TX_NAK  = 2'd3
    } tx_pkt_t;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_OUT_WAIT_DATA = 3'd1,
        ST_TX_START      = 3'd2,
        ST_TX_BUSY       = 3'd3,
        ST_IN_WAIT_ACK   = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/usb_resp_timer.sv
// Inter-packet response timer.
//   clk, n_rst : clock, async active-low reset
//   clear      : forces the count back to zero (wins over enable)
//   enable     : advance the count by one
//   timeout    : count has reached TIMEOUT-1
// The count holds at TIMEOUT-1 so the flag stays up until cleared.
module usb_resp_timer #(
    parameter int unsigned TIMEOUT = 144,
    parameter int unsigned CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    logic [CNT_W-1:0] count;

    assign timeout = (count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !timeout) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/usb_protocol_ctrl.sv
// Endpoint-level transaction sequencer for the USB bulk endpoint.
// Decides the response to each host token, launches TX, owns the bus
// direction and issues buffer clear/rewind commands.
//   rx_packet_valid/rx_packet/rx_error : decode results from RX control
//   buffer_occupancy, tx_data_ready    : data buffer status
//   tx_done                            : TX finished sending EOP
//   tx_start/tx_packet                 : TX launch and packet type
//   d_mode                             : 1 = device drives the bus
//   clear_buffer/rewind_buffer         : buffer commands (pulses)
//   data_sent/data_received/proto_error: status pulses
//
// state            | meaning
// ST_IDLE          | waiting for an OUT or IN token
// ST_OUT_WAIT_DATA | OUT token seen, waiting for the host DATA packet
// ST_TX_START      | single cycle launching TX
// ST_TX_BUSY       | TX sending, waiting for tx_done
// ST_IN_WAIT_ACK   | IN data sent, waiting for the host handshake
module usb_protocol_ctrl
    import usb_pkg::*;
#(
    parameter int unsigned RESP_TIMEOUT = RESP_TIMEOUT_DEF,
    parameter int unsigned BUF_ADDR_W   = 7
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  rx_packet_valid,
    input  logic [2:0]            rx_packet,
    input  logic                  rx_error,
    input  logic [BUF_ADDR_W-1:0] buffer_occupancy,
    input  logic                  tx_data_ready,
    input  logic                  tx_done,
    output logic                  tx_start,
    output logic [1:0]            tx_packet,
    output logic                  d_mode,
    output logic                  clear_buffer,
    output logic                  rewind_buffer,
    output logic                  data_sent,
    output logic                  data_received,
    output logic                  proto_error
);

    ctrl_state_t state, state_n;
    tx_pkt_t     tx_pkt_q, tx_pkt_n;
    rx_pkt_t     rx_pkt;
    logic        out_ok, out_ok_n;
    logic        clear_n, rewind_n, sent_n, recv_n, perr_n;
    logic        pkt_seen;
    logic        timeout;
    logic        tmr_clear, tmr_en;

    assign rx_pkt   = rx_pkt_t'(rx_packet);
    // An RX error in the same cycle as a packet discards the packet.
    assign pkt_seen = rx_packet_valid && !rx_error;

    assign tmr_clear = (state_n != state);
    assign tmr_en    = (state == ST_OUT_WAIT_DATA) || (state == ST_IN_WAIT_ACK);

    usb_resp_timer #(
        .TIMEOUT (RESP_TIMEOUT)
    ) u_resp_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .timeout (timeout)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= ST_IDLE;
            tx_pkt_q      <= TX_NONE;
            out_ok        <= 1'b0;
            clear_buffer  <= 1'b0;
            rewind_buffer <= 1'b0;
            data_sent     <= 1'b0;
            data_received <= 1'b0;
            proto_error   <= 1'b0;
        end else begin
            state         <= state_n;
            tx_pkt_q      <= tx_pkt_n;
            out_ok        <= out_ok_n;
            clear_buffer  <= clear_n;
            rewind_buffer <= rewind_n;
            data_sent     <= sent_n;
            data_received <= recv_n;
            proto_error   <= perr_n;
        end
    end

    always_comb begin
        state_n  = state;
        tx_pkt_n = tx_pkt_q;
        out_ok_n = out_ok;
        clear_n  = 1'b0;
        rewind_n = 1'b0;
        sent_n   = 1'b0;
        recv_n   = 1'b0;
        perr_n   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pkt_seen && rx_pkt == RX_OUT) begin
                    state_n  = ST_OUT_WAIT_DATA;
                    out_ok_n = (buffer_occupancy == '0);
                end else if (pkt_seen && rx_pkt == RX_IN) begin
                    state_n  = ST_TX_START;
                    tx_pkt_n = (tx_data_ready && buffer_occupancy != '0) ? TX_DATA : TX_NAK;
                end
            end

            ST_OUT_WAIT_DATA: begin
                if (rx_error) begin
                    clear_n = 1'b1;
                    perr_n  = 1'b1;
                    state_n = ST_IDLE;
                end else if (rx_packet_valid) begin
                    if (rx_pkt == RX_DATA) begin
                        state_n = ST_TX_START;
                        if (out_ok) begin
                            tx_pkt_n = TX_ACK;
                            recv_n   = 1'b1;
                        end else begin
                            // Buffer still holds earlier data; leave it intact.
                            tx_pkt_n = TX_NAK;
                        end
                    end else begin
                        perr_n  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end else if (timeout) begin
                    clear_n = 1'b1;
                    perr_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end

            ST_TX_START: begin
                state_n = ST_TX_BUSY;
            end

            ST_TX_BUSY: begin
                if (tx_done) begin
                    state_n  = (tx_pkt_q == TX_DATA) ? ST_IN_WAIT_ACK : ST_IDLE;
                    tx_pkt_n = TX_NONE;
                end
            end

            ST_IN_WAIT_ACK: begin
                if (pkt_seen && rx_pkt == RX_ACK) begin
                    clear_n = 1'b1;
                    sent_n  = 1'b1;
                    state_n = ST_IDLE;
                end else if (rx_error || rx_packet_valid || timeout) begin
                    // Anything but ACK (NAK included) means the host did not
                    // take the data: rewind so the retry resends it.
                    rewind_n = 1'b1;
                    perr_n   = 1'b1;
                    state_n  = ST_IDLE;
                end
            end

            default: begin
                state_n  = ST_IDLE;
                tx_pkt_n = TX_NONE;
            end
        endcase
    end

    assign tx_start  = (state == ST_TX_START);
    assign d_mode    = (state == ST_TX_START) || (state == ST_TX_BUSY);
    assign tx_packet = tx_pkt_q;

endmodule

// File: tb/tb_usb_protocol_ctrl.sv
module tb_usb_protocol_ctrl;
    import usb_pkg::*;

    localparam int TMO = 144;

    logic       clk;
    logic       n_rst;
    logic       rx_packet_valid;
    logic [2:0] rx_packet;
    logic       rx_error;
    logic [6:0] buffer_occupancy;
    logic       tx_data_ready;
    logic       tx_done;
    logic       tx_start;
    logic [1:0] tx_packet;
    logic       d_mode;
    logic       clear_buffer;
    logic       rewind_buffer;
    logic       data_sent;
    logic       data_received;
    logic       proto_error;

    int errors = 0;
    int checks = 0;

    // pulse counters sampled on the falling edge
    int n_clear = 0, n_rewind = 0, n_sent = 0, n_recv = 0, n_perr = 0, n_txs = 0;
    int b_clear, b_rewind, b_sent, b_recv, b_perr, b_txs;

    usb_protocol_ctrl dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .rx_packet_valid  (rx_packet_valid),
        .rx_packet        (rx_packet),
        .rx_error         (rx_error),
        .buffer_occupancy (buffer_occupancy),
        .tx_data_ready    (tx_data_ready),
        .tx_done          (tx_done),
        .tx_start         (tx_start),
        .tx_packet        (tx_packet),
        .d_mode           (d_mode),
        .clear_buffer     (clear_buffer),
        .rewind_buffer    (rewind_buffer),
        .data_sent        (data_sent),
        .data_received    (data_received),
        .proto_error      (proto_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clear_buffer)  n_clear++;
        if (rewind_buffer) n_rewind++;
        if (data_sent)     n_sent++;
        if (data_received) n_recv++;
        if (proto_error)   n_perr++;
        if (tx_start)      n_txs++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pkt(input logic [2:0] p, input logic err);
        rx_packet_valid = 1'b1;
        rx_packet       = p;
        rx_error        = err;
        step();
        rx_packet_valid = 1'b0;
        rx_packet       = 3'd0;
        rx_error        = 1'b0;
    endtask

    task automatic snap();
        b_clear = n_clear; b_rewind = n_rewind; b_sent = n_sent;
        b_recv = n_recv; b_perr = n_perr; b_txs = n_txs;
    endtask

    // total pulse counts since snap(): catches stretched or stray pulses
    task automatic end_deltas(input string tag, input int e_clear, input int e_rewind,
                              input int e_sent, input int e_recv, input int e_perr, input int e_txs);
        @(negedge clk);
        #1;
        chk({tag, "_n_clear"},  n_clear  - b_clear,  e_clear);
        chk({tag, "_n_rewind"}, n_rewind - b_rewind, e_rewind);
        chk({tag, "_n_sent"},   n_sent   - b_sent,   e_sent);
        chk({tag, "_n_recv"},   n_recv   - b_recv,   e_recv);
        chk({tag, "_n_perr"},   n_perr   - b_perr,   e_perr);
        chk({tag, "_n_txs"},    n_txs    - b_txs,    e_txs);
    endtask

    task automatic busy_then_done(input string tag, input logic [1:0] exp_pkt);
        int busy;
        busy = $urandom_range(0, 6);
        repeat (busy) begin
            chk({tag, "_busy_dmode"}, d_mode, 1);
            chk({tag, "_busy_pkt"}, tx_packet, exp_pkt);
            step();
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk({tag, "_done_dmode"}, d_mode, 0);
        chk({tag, "_done_pkt"}, tx_packet, TX_NONE);
        chk({tag, "_done_txs"}, tx_start, 0);
    endtask

    // kind: 0 DATA, 1 rx_error with DATA, 2 unexpected packet, 3 timeout
    task automatic out_txn(input int occ, input int gap, input int kind);
        logic       exp_recv;
        logic [1:0] exp_pkt;
        logic [2:0] others [5];
        others = '{RX_NONE, RX_OUT, RX_IN, RX_ACK, RX_NAK};
        exp_recv = (occ == 0);
        exp_pkt  = exp_recv ? TX_ACK : TX_NAK;
        snap();
        buffer_occupancy = 7'(occ);
        drive_pkt(RX_OUT, 1'b0);
        chk("out_tok_dmode", d_mode, 0);
        chk("out_tok_txs", tx_start, 0);
        // occupancy is latched at the token; later changes must not matter
        buffer_occupancy = 7'($urandom_range(0, 64));
        tx_data_ready = 1'($urandom_range(0, 1));
        case (kind)
            0: begin
                repeat (gap) step();
                drive_pkt(RX_DATA, 1'b0);
                chk("out_ack_txs", tx_start, 1);
                chk("out_ack_dmode", d_mode, 1);
                chk("out_ack_pkt", tx_packet, exp_pkt);
                chk("out_ack_recv", data_received, exp_recv);
                chk("out_ack_clear", clear_buffer, 0);
                step();
                chk("out_ack_txs2", tx_start, 0);
                chk("out_ack_dmode2", d_mode, 1);
                busy_then_done("out", exp_pkt);
                end_deltas("out", 0, 0, 0, int'(exp_recv), 0, 1);
            end
            1: begin
                repeat (gap) step();
                drive_pkt(RX_DATA, 1'b1);
                chk("out_err_clear", clear_buffer, 1);
                chk("out_err_perr", proto_error, 1);
                chk("out_err_txs", tx_start, 0);
                step();
                chk("out_err_idle_dmode", d_mode, 0);
                end_deltas("out_err", 1, 0, 0, 0, 1, 0);
            end
            2: begin
                repeat (gap) step();
                drive_pkt(others[$urandom_range(0, 4)], 1'b0);
                chk("out_bad_perr", proto_error, 1);
                chk("out_bad_clear", clear_buffer, 0);
                chk("out_bad_txs", tx_start, 0);
                end_deltas("out_bad", 0, 0, 0, 0, 1, 0);
            end
            default: begin
                repeat (TMO - 1) step();
                chk("out_tmo_early", proto_error, 0);
                step();
                chk("out_tmo_perr", proto_error, 1);
                chk("out_tmo_clear", clear_buffer, 1);
                end_deltas("out_tmo", 1, 0, 0, 0, 1, 0);
            end
        endcase
    endtask

    // reply: 0 ACK, 1 NAK, 2 other packet, 3 rx_error, 4 timeout
    task automatic in_txn(input logic rdy, input int occ, input int gap, input int reply);
        logic [1:0] exp_pkt;
        logic       ok;
        logic [2:0] others [4];
        others = '{RX_NONE, RX_OUT, RX_IN, RX_DATA};
        exp_pkt = (rdy && occ != 0) ? TX_DATA : TX_NAK;
        snap();
        tx_data_ready = rdy;
        buffer_occupancy = 7'(occ);
        drive_pkt(RX_IN, 1'b0);
        chk("in_txs", tx_start, 1);
        chk("in_dmode", d_mode, 1);
        chk("in_pkt", tx_packet, exp_pkt);
        step();
        chk("in_txs2", tx_start, 0);
        chk("in_dmode2", d_mode, 1);
        busy_then_done("in", exp_pkt);
        if (exp_pkt != TX_DATA) begin
            end_deltas("in_nak", 0, 0, 0, 0, 0, 1);
            return;
        end
        if (reply == 4) begin
            repeat (TMO - 1) step();
            chk("in_tmo_early", rewind_buffer, 0);
            step();
            chk("in_tmo_rewind", rewind_buffer, 1);
            chk("in_tmo_perr", proto_error, 1);
            chk("in_tmo_clear", clear_buffer, 0);
            end_deltas("in_tmo", 0, 1, 0, 0, 1, 1);
            return;
        end
        repeat (gap) step();
        case (reply)
            0: drive_pkt(RX_ACK, 1'b0);
            1: drive_pkt(RX_NAK, 1'b0);
            2: drive_pkt(others[$urandom_range(0, 3)], 1'b0);
            default: drive_pkt(RX_ACK, 1'b1);
        endcase
        ok = (reply == 0);
        chk("in_rep_clear", clear_buffer, ok);
        chk("in_rep_sent", data_sent, ok);
        chk("in_rep_rewind", rewind_buffer, !ok);
        chk("in_rep_perr", proto_error, !ok);
        chk("in_rep_dmode", d_mode, 0);
        end_deltas("in_rep", int'(ok), int'(!ok), int'(ok), 0, int'(!ok), 1);
    endtask

    initial begin
        n_rst = 1'b0;
        rx_packet_valid = 1'b0;
        rx_packet = 3'd0;
        rx_error = 1'b0;
        buffer_occupancy = 7'd0;
        tx_data_ready = 1'b0;
        tx_done = 1'b0;
        repeat (2) step();
        chk("rst_txs", tx_start, 0);
        chk("rst_pkt", tx_packet, TX_NONE);
        chk("rst_dmode", d_mode, 0);
        chk("rst_pulses", {clear_buffer, rewind_buffer, data_sent, data_received, proto_error}, 0);
        n_rst = 1'b1;
        step();

        // idle: errors, stray packets and tx_done are ignored
        snap();
        tx_data_ready = 1'b1;
        buffer_occupancy = 7'd8;
        drive_pkt(RX_IN, 1'b1);
        chk("idle_err_txs", tx_start, 0);
        drive_pkt(RX_ACK, 1'b0);
        chk("idle_ack_perr", proto_error, 0);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("idle_done_dmode", d_mode, 0);
        end_deltas("idle", 0, 0, 0, 0, 0, 0);

        out_txn(0, 9, 0);
        out_txn(5, 3, 0);
        in_txn(1'b1, 8, 19, 0);
        in_txn(1'b0, 8, 0, 0);
        in_txn(1'b1, 0, 0, 0);
        in_txn(1'b1, 64, 0, 1);
        in_txn(1'b1, 12, 0, 4);
        out_txn(0, 2, 1);
        out_txn(3, 0, 3);
        out_txn(0, 1, 2);
        in_txn(1'b1, 1, 4, 3);

        // reset in the middle of TX
        snap();
        tx_data_ready = 1'b1;
        buffer_occupancy = 7'd8;
        drive_pkt(RX_IN, 1'b0);
        step();
        chk("mrst_busy_dmode", d_mode, 1);
        #2 n_rst = 1'b0;
        #1;
        chk("mrst_dmode", d_mode, 0);
        chk("mrst_pkt", tx_packet, TX_NONE);
        #2 n_rst = 1'b1;
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("mrst_done_dmode", d_mode, 0);
        chk("mrst_done_txs", tx_start, 0);
        step();
        chk("mrst_after_dmode", d_mode, 0);
        end_deltas("mrst", 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 24; i++) begin
            int occ;
            occ = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 64));
            if ($urandom_range(0, 1) == 0)
                out_txn(occ, $urandom_range(0, 120), $urandom_range(0, 3));
            else
                in_txn(1'($urandom_range(0, 1)), occ, $urandom_range(0, 120), $urandom_range(0, 4));
            repeat ($urandom_range(0, 3)) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
